countdown_timer_ctrl: RTL

- Parametrised successor to the board-level countdown FSM.
- Sequences IDLE → SET → ARMED → RUN ⇄ PAUSE → DONE with a generic count width, an internal tick prescaler and an LED blink generator.
- Drives the 7-segment display datapath (value + enable) and the LED bank.
- Sits between the button debouncers/edge detectors and the display/LED drivers in the top level.

---
 rtl/countdown_pkg.sv | 16 +
 rtl/tick_prescaler.sv | 28 ++
 rtl/countdown_timer_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/countdown_pkg.sv
// Shared state encoding and default prescaler divisors for the countdown timer controller.
package countdown_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StSet   = 3'd1,
    StArmed = 3'd2,
    StRun   = 3'd3,
    StPause = 3'd4,
    StDone  = 3'd5
  } state_t;

  localparam int unsigned DefaultTickDiv  = 100_000_000;
  localparam int unsigned DefaultBlinkDiv = 25_000_000;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider: tick is high for one cycle when the counter sits at DIV-1 while enabled.
module tick_prescaler #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CntW-1:0] Last = CntW'(DIV - 1);

  logic [CntW-1:0] cnt_q;

  assign tick = en && (cnt_q == Last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tick ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/countdown_timer_ctrl.sv
// Countdown timer sequencer: IDLE -> SET -> ARMED -> RUN <-> PAUSE -> DONE.
// Define COUNTDOWN_AUTO_RELOAD_EN to reload the count at zero instead of finishing.
module countdown_timer_ctrl
  import countdown_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned TICK_DIV  = DefaultTickDiv,
  parameter int unsigned BLINK_DIV = DefaultBlinkDiv,
  parameter int unsigned LED_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw,
  input  logic             start_p,
  input  logic             clear_p,
  output logic [WIDTH-1:0] value_out,
  output logic             disp_en,
  output logic [LED_W-1:0] led,
  output logic [2:0]       state_out,
  output logic             done
);

  state_t           state_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] latched_q;
  logic [LED_W-1:0] led_q;
  logic             reload_q;
  logic             count_tick;
  logic             blink_tick;
  logic             count_clr;
  logic             blink_clr;

  assign count_clr = clear_p || ((state_q == StArmed) && start_p);
  assign blink_clr = clear_p || (state_q != StDone);

  tick_prescaler #(
    .DIV(TICK_DIV)
  ) u_count_div (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (state_q == StRun),
    .clr  (count_clr),
    .tick (count_tick)
  );

  tick_prescaler #(
    .DIV(BLINK_DIV)
  ) u_blink_div (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (state_q == StDone),
    .clr  (blink_clr),
    .tick (blink_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      count_q   <= '0;
      latched_q <= '0;
      led_q     <= '0;
      reload_q  <= 1'b0;
    end else begin
      reload_q <= 1'b0;
      if (clear_p) begin
        state_q <= StIdle;
        count_q <= '0;
        led_q   <= '0;
      end else begin
        case (state_q)
          StIdle: if (start_p) state_q <= StSet;
          StSet: begin
            if (start_p) begin
              latched_q <= sw;
              state_q   <= StArmed;
            end
          end
          StArmed: begin
            if (start_p) begin
              count_q <= latched_q;
              if (latched_q == '0) begin
                state_q <= StDone;
                led_q   <= '1;
              end else begin
                state_q <= StRun;
                led_q   <= '0;
              end
            end
          end
          StRun: begin
            // Zero is never decremented; reaching zero overrides a coincident pause.
            if (count_tick && (count_q == WIDTH'(1))) begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
              count_q  <= latched_q;
              reload_q <= 1'b1;
              led_q    <= ~led_q;
              if (start_p) state_q <= StPause;
`else
              count_q <= '0;
              state_q <= StDone;
              led_q   <= '1;
`endif
            end else begin
              if (count_tick && (count_q != '0)) count_q <= count_q - 1'b1;
              if (start_p) state_q <= StPause;
            end
          end
          StPause: if (start_p) state_q <= StRun;
          StDone: begin
            if (start_p) begin
              state_q <= StArmed;
              led_q   <= '0;
            end else if (blink_tick) begin
              led_q <= ~led_q;
            end
          end
          default: begin
            state_q <= StIdle;
            led_q   <= '0;
          end
        endcase
      end
    end
  end

  always_comb begin
    value_out = '0;
    case (state_q)
      StSet:           value_out = sw;
      StArmed:         value_out = latched_q;
      StRun, StPause:  value_out = count_q;
      default:         value_out = '0;
    endcase
  end

  assign disp_en   = (state_q == StArmed) || (state_q == StRun) ||
                     (state_q == StPause) || (state_q == StDone);
  assign led       = led_q;
  assign state_out = state_q;
  assign done      = (state_q == StDone) || reload_q;

endmodule
